// File: rtl/pipeline_ctrl_if.sv
// Hazard inputs and stall/flush controls between the pipeline datapath and pipeline_ctrl.
interface pipeline_ctrl_if;
  localparam int unsigned REG_W = 5;
  localparam int unsigned CNT_W = 32;

  logic [REG_W-1:0] i_id_rs1;
  logic [REG_W-1:0] i_id_rs2;
  logic             i_id_rs1_en;
  logic             i_id_rs2_en;
  logic [REG_W-1:0] i_ex_rd;
  logic             i_ex_mem_read;
  logic             i_ex_redirect;
  logic             i_imem_valid;
  logic             i_dmem_stall;
  logic             i_cnt_clr;

  logic             o_pc_stall;
  logic             o_ifid_stall;
  logic             o_ifid_flush;
  logic             o_idex_stall;
  logic             o_idex_flush;
  logic             o_exmem_stall;
  logic             o_memwb_flush;
  logic             o_redirect_pending;
  logic [CNT_W-1:0] o_stall_cnt;
  logic [CNT_W-1:0] o_flush_cnt;

  // Datapath side: reports hazards, consumes controls.
  modport master (
    output i_id_rs1, i_id_rs2, i_id_rs1_en, i_id_rs2_en, i_ex_rd, i_ex_mem_read,
           i_ex_redirect, i_imem_valid, i_dmem_stall, i_cnt_clr,
    input  o_pc_stall, o_ifid_stall, o_ifid_flush, o_idex_stall, o_idex_flush,
           o_exmem_stall, o_memwb_flush, o_redirect_pending, o_stall_cnt, o_flush_cnt
  );

  // Controller side.
  modport slave (
    input  i_id_rs1, i_id_rs2, i_id_rs1_en, i_id_rs2_en, i_ex_rd, i_ex_mem_read,
           i_ex_redirect, i_imem_valid, i_dmem_stall, i_cnt_clr,
    output o_pc_stall, o_ifid_stall, o_ifid_flush, o_idex_stall, o_idex_flush,
           o_exmem_stall, o_memwb_flush, o_redirect_pending, o_stall_cnt, o_flush_cnt
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline hazard controller: freeze, redirect/drain, load-use and fetch-miss
// handling with stall and redirect performance counters.
module pipeline_ctrl #(
  // Counter ceiling; lowered only to reach saturation in short simulations.
  parameter int unsigned CNT_SAT = 32'hFFFF_FFFF
) (
  input  logic           i_clk,
  input  logic           i_reset,
  pipeline_ctrl_if.slave bus
);
  localparam int unsigned CNT_W = 32;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_lu_block;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic w_freeze;
  logic w_redirect;
  logic w_lu_hit;
  logic w_load_use;
  logic w_pc_stall;
  logic w_ifid_stall;
  logic w_ifid_flush;
  logic w_idex_stall;
  logic w_idex_flush;
  logic w_exmem_stall;
  logic w_memwb_flush;
  logic w_redirect_pending;

  // Condition decode in priority order; load-use is masked for the cycle after it fired
  // because the bubble it inserted is what occupies EX then.
  assign w_freeze   = bus.i_dmem_stall;
  assign w_redirect = bus.i_ex_redirect & ~w_freeze;
  assign w_lu_hit   = bus.i_ex_mem_read && (bus.i_ex_rd != 5'd0) &&
                      ((bus.i_id_rs1_en && (bus.i_id_rs1 == bus.i_ex_rd)) ||
                       (bus.i_id_rs2_en && (bus.i_id_rs2 == bus.i_ex_rd)));
  assign w_load_use = w_lu_hit && (r_state == ST_RUN) && !w_freeze &&
                      !bus.i_ex_redirect && !r_lu_block;

  // State register.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) r_state <= ST_RUN;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic: freeze holds, redirect picks DRAIN on a missing fetch, DRAIN exits
  // once the wrong-path word has arrived.
  always_comb begin
    w_state_nxt = r_state;
    if (w_freeze) begin
      w_state_nxt = r_state;
    end else if (bus.i_ex_redirect) begin
      w_state_nxt = bus.i_imem_valid ? ST_RUN : ST_DRAIN;
    end else if ((r_state == ST_DRAIN) && bus.i_imem_valid) begin
      w_state_nxt = ST_RUN;
    end
  end

  // Output decode; during reset the downstream registers are flushed.
  always_comb begin
    w_pc_stall         = 1'b0;
    w_ifid_stall       = 1'b0;
    w_ifid_flush       = 1'b0;
    w_idex_stall       = 1'b0;
    w_idex_flush       = 1'b0;
    w_exmem_stall      = 1'b0;
    w_memwb_flush      = 1'b0;
    w_redirect_pending = 1'b0;
    if (!i_reset) begin
      w_ifid_flush  = 1'b1;
      w_idex_flush  = 1'b1;
      w_memwb_flush = 1'b1;
    end else begin
      w_redirect_pending = (r_state == ST_DRAIN);
      if (w_freeze) begin
        w_pc_stall    = 1'b1;
        w_ifid_stall  = 1'b1;
        w_idex_stall  = 1'b1;
        w_exmem_stall = 1'b1;
        w_memwb_flush = 1'b1;
      end else if (w_redirect) begin
        w_ifid_flush = 1'b1;
        w_idex_flush = 1'b1;
      end else if (r_state == ST_DRAIN) begin
        w_pc_stall   = 1'b1;
        w_ifid_flush = 1'b1;
      end else if (w_load_use) begin
        w_pc_stall   = 1'b1;
        w_ifid_stall = 1'b1;
        w_idex_flush = 1'b1;
      end else if (!bus.i_imem_valid) begin
        w_pc_stall   = 1'b1;
        w_ifid_flush = 1'b1;
      end
    end
  end

  // Load-use mask: set when the bubble is inserted, held across a freeze so the bubble
  // still sitting in ID/EX is not mistaken for a fresh hazard.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset)        r_lu_block <= 1'b0;
    else if (w_load_use) r_lu_block <= 1'b1;
    else if (!w_freeze)  r_lu_block <= 1'b0;
  end

  // Saturating performance counters; clear wins over increment.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (bus.i_cnt_clr) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_pc_stall && (r_stall_cnt != CNT_W'(CNT_SAT))) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_redirect && (r_flush_cnt != CNT_W'(CNT_SAT))) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign bus.o_pc_stall         = w_pc_stall;
  assign bus.o_ifid_stall       = w_ifid_stall;
  assign bus.o_ifid_flush       = w_ifid_flush;
  assign bus.o_idex_stall       = w_idex_stall;
  assign bus.o_idex_flush       = w_idex_flush;
  assign bus.o_exmem_stall      = w_exmem_stall;
  assign bus.o_memwb_flush      = w_memwb_flush;
  assign bus.o_redirect_pending = w_redirect_pending;
  assign bus.o_stall_cnt        = r_stall_cnt;
  assign bus.o_flush_cnt        = r_flush_cnt;

endmodule
